// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared types and constants for the LDPC frame controller
package ldpc_pkg;

    // Frame controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ldpc_state_t;

    // Bit positions inside out_status
    localparam int STATUS_CONV  = 0;
    localparam int STATUS_LIMIT = 1;

    // Default geometry of the decoder core
    localparam int LDPC_DATA_W = 5;
    localparam int LDPC_R      = 24;
    localparam int LDPC_D      = 96;
    localparam int LDPC_ITER_W = 6;
    localparam int LDPC_NB     = LDPC_R * LDPC_D;
    localparam int LDPC_LLR_W  = LDPC_NB * LDPC_DATA_W;

endpackage

// File: rtl/ldpc_llr_buf.sv
// rtl/ldpc_llr_buf.sv - single-entry pending frame buffer with registered ready
//  clk, rst_n          clock, async active-low reset
//  in_valid/in_ready   producer handshake; in_ready is registered (~next buf_valid)
//  in_data             payload {llr, max_eff, et_en}
//  buf_valid/buf_data  held entry
//  pop                 consumer takes the entry this cycle
module ldpc_llr_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         buf_valid,
    output logic [W-1:0] buf_data,
    input  logic         pop
);

    logic accept;
    logic valid_next;

    assign accept = in_valid & in_ready;
    // A refill in the same cycle as a pop keeps the entry valid.
    assign valid_next = accept | (buf_valid & ~pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            in_ready  <= 1'b0;
            buf_data  <= '0;
        end else begin
            buf_valid <= valid_next;
            in_ready  <= ~valid_next;
            if (accept) begin
                buf_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/ldpc_frame_ctrl.sv
// rtl/ldpc_frame_ctrl.sv - LDPC decoder frame controller (buffering, iteration control, result)
//  clk, rst_n                      clock, async active-low reset
//  in_valid/in_ready/in_llr        input frame handshake and channel LLRs
//  in_max_iter, in_et_en           per-frame iteration limit (0 -> 1) and early-termination enable
//  dp_llr, dp_clr, dp_en           datapath LLRs, CNU clear pulse, iteration step
//  dp_dec, dp_chk_ok               datapath hard decisions and parity-check result
//  out_valid/out_ready             result handshake
//  out_res, out_iter, out_status   decoded bits, iterations run, {limit_reached, converged}
module ldpc_frame_ctrl
    import ldpc_pkg::*;
#(
    parameter int DATA_W = LDPC_DATA_W,
    parameter int R      = LDPC_R,
    parameter int D      = LDPC_D,
    parameter int ITER_W = LDPC_ITER_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [R*D*DATA_W-1:0] in_llr,
    input  logic [ITER_W-1:0]    in_max_iter,
    input  logic                 in_et_en,
    output logic [R*D*DATA_W-1:0] dp_llr,
    output logic                 dp_clr,
    output logic                 dp_en,
    input  logic [R*D-1:0]       dp_dec,
    input  logic                 dp_chk_ok,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [R*D-1:0]       out_res,
    output logic [ITER_W-1:0]    out_iter,
    output logic [1:0]           out_status
);

    localparam int NB    = R * D;
    localparam int LLR_W = NB * DATA_W;
    localparam int BUF_W = LLR_W + ITER_W + 1;

    ldpc_state_t state, state_next;

    logic [ITER_W-1:0] max_eff_in;
    logic [BUF_W-1:0]  pbuf_data;
    logic              pbuf_v;
    logic [LLR_W-1:0]  pbuf_llr;
    logic [ITER_W-1:0] pbuf_max;
    logic              pbuf_et;

    logic [ITER_W-1:0] cnt;
    logic [ITER_W-1:0] max_eff;
    logic              et_en;

    logic stop_et;
    logic stop_lim;
    logic stop;
    logic load;

    // A zero limit still runs one iteration.
    assign max_eff_in = (in_max_iter == '0) ? ITER_W'(1) : in_max_iter;

    ldpc_llr_buf #(.W(BUF_W)) u_pbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_llr, max_eff_in, in_et_en}),
        .buf_valid (pbuf_v),
        .buf_data  (pbuf_data),
        .pop       (load)
    );

    assign {pbuf_llr, pbuf_max, pbuf_et} = pbuf_data;

    // Early stop needs at least one completed iteration so dp_chk_ok reflects real decisions.
    assign stop_et  = et_en & (cnt != '0) & dp_chk_ok;
    assign stop_lim = (cnt == max_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pbuf_v) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN:   if (stop_et || stop_lim) state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = pbuf_v ? ST_CLEAR : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dp_clr = (state == ST_CLEAR);
        stop   = (state == ST_RUN) & (stop_et | stop_lim);
        dp_en  = (state == ST_RUN) & ~stop;
        // Pending frame moves to the datapath only when entering CLEAR.
        load   = pbuf_v & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_llr     <= '0;
            max_eff    <= '0;
            et_en      <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_iter   <= '0;
            out_status <= '0;
        end else begin
            if (load) begin
                dp_llr  <= pbuf_llr;
                max_eff <= pbuf_max;
                et_en   <= pbuf_et;
            end

            if (dp_clr) begin
                cnt <= '0;
            end else if (dp_en) begin
                cnt <= cnt + ITER_W'(1);
            end

            if (stop) begin
                out_res   <= dp_dec;
                out_iter  <= cnt;
                out_valid <= 1'b1;
                if (stop_et) begin
                    out_status <= 2'b01;
                end else begin
                    out_status[STATUS_LIMIT] <= 1'b1;
                    out_status[STATUS_CONV]  <= dp_chk_ok;
                end
            end else if ((state == ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
